// File: rtl/burst_reader_pkg.sv
// rtl/burst_reader_pkg.sv - shared constants and helpers for burst_reader
// Purpose: FSM state encoding, AXI length field width and the per-burst
//          byte-address increment used by burst_reader.
// Contents:
//   S_IDLE/S_REQ/S_DATA - FSM state codes
//   LEN_W               - width of the AXI beats-minus-one length field
//   byte_incr()         - bytes covered by a burst of (len+1) beats
package burst_reader_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam int LEN_W = 8;

  // len is AXI-encoded (beats-1); width is the beat width in bits.
  function automatic logic [31:0] byte_incr(input logic [LEN_W-1:0] len,
                                            input int unsigned width);
    return (32'(len) + 32'd1) * (width / 32'd8);
  endfunction

endpackage

// File: rtl/burst_reader.sv
// rtl/burst_reader.sv - drains a sync FIFO into fixed-length AXI write bursts
// Purpose: watches the FIFO level, issues one (addr, len) request per burst
//          and then passes exactly len+1 beats through, marking the last.
//          flush_i (and optionally an idle timeout) emits a short burst.
// Optional: define BURST_READER_TIMEOUT_EN to add the idle-timeout flush.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   enable_i                - allows new bursts to start
//   flush_i                 - level request to emit residual data
//   level_i, fwready_i      - FIFO occupancy (lags 1 cycle) and write-ready
//   valid_i/ready_o/data_i  - FIFO read side
//   req_valid_o/req_ready_i - burst request handshake
//   req_len_o, req_addr_o   - beats-1 and byte address of the burst
//   valid_o/ready_i/last_o/data_o - output beat stream
//   busy_o                  - FSM not idle
module burst_reader
  import burst_reader_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          ABITS   = 4,
  parameter int          BURST   = 8,
  parameter int          ADDRS   = 27,
  parameter int unsigned BASE    = 0,
  parameter int          TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic [ABITS-1:0] level_i,
  input  logic             fwready_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [7:0]       req_len_o,
  output logic [ADDRS-1:0] req_addr_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  localparam logic [ABITS:0] DEPTH_LEV = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] BURST_LEV = (ABITS+1)'(BURST);
  localparam logic [ABITS:0] ONE_LEV   = {{ABITS{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [ADDRS-1:0] addr_q;
  logic [ABITS:0]   lev;
  logic             flush_eff;
  logic             timeout_hit;
  logic             start;
  logic [LEN_W-1:0] len_next;
  logic             in_data;

  // A full FIFO wraps its level to 0; fwready low with data visible means DEPTH.
  always_comb begin
    lev = {1'b0, level_i};
    if (!fwready_i && valid_i) lev = DEPTH_LEV;
  end

`ifdef BURST_READER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_hit = (idle_cnt >= 16'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state == S_IDLE && (lev != '0 || valid_i)) begin
      if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign flush_eff = flush_i || timeout_hit;

  // Full burst takes priority over a flush. The lev=0/valid_i case drains a
  // word that sits only in the FIFO output register (not counted in level).
  always_comb begin
    start    = 1'b0;
    len_next = LEN_W'(BURST - 1);
    if (lev >= BURST_LEV) begin
      start    = 1'b1;
      len_next = LEN_W'(BURST - 1);
    end else if (flush_eff && lev != '0) begin
      start    = 1'b1;
      len_next = LEN_W'(lev - ONE_LEV);
    end else if (flush_eff && valid_i) begin
      start    = 1'b1;
      len_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      len_q  <= '0;
      count  <= '0;
      addr_q <= ADDRS'(BASE);
    end else begin
      case (state)
        S_IDLE: begin
          if (enable_i && start) begin
            len_q <= len_next;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready_i) begin
            state  <= S_DATA;
            count  <= '0;
            addr_q <= addr_q + ADDRS'(byte_incr(len_q, WIDTH));
          end
        end
        S_DATA: begin
          if (valid_i && ready_i) begin
            if (count == len_q) state <= S_IDLE;
            else                count <= count + ONE_LEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_data     = (state == S_DATA);
  assign req_valid_o = (state == S_REQ);
  assign req_len_o   = len_q;
  assign req_addr_o  = addr_q;
  assign valid_o     = in_data && valid_i;
  assign ready_o     = in_data && ready_i;
  assign data_o      = data_i;
  assign last_o      = valid_o && (count == len_q);
  assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_burst_reader.sv
// tb/tb_burst_reader.sv - self-checking bench for burst_reader with a FIFO model
module tb_burst_reader;

  localparam int WIDTH = 32, ABITS = 4, BURST = 8, ADDRS = 6, TIMEOUT = 64;

  logic             clock = 1'b0, reset = 1'b1;
  logic             enable_i = 1'b0, flush_i = 1'b0;
  logic [ABITS-1:0] level_i = '0;
  logic             fwready_i = 1'b1, valid_i = 1'b0, ready_o;
  logic [WIDTH-1:0] data_i = '0, data_o;
  logic             req_valid_o, req_ready_i = 1'b1;
  logic [7:0]       req_len_o;
  logic [ADDRS-1:0] req_addr_o;
  logic             valid_o, ready_i = 1'b1, last_o, busy_o;

  always #5 clock = ~clock;

  burst_reader #(.WIDTH(WIDTH), .ABITS(ABITS), .BURST(BURST), .ADDRS(ADDRS),
                 .BASE(0), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable_i(enable_i), .flush_i(flush_i),
    .level_i(level_i), .fwready_i(fwready_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_len_o(req_len_o), .req_addr_o(req_addr_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .data_o(data_o), .busy_o(busy_o));

  int checks = 0, failures = 0;

  // FIFO model: memory words counted by level, plus one output register that
  // refills only while the reader is ready (so it is not counted in level).
  logic [WIDTH-1:0] mem[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] out_reg = '0;
  bit               out_valid = 0;
  int               push_n = 0, push_prob = 100;
  bit               seq_data = 1, rand_rdy = 0;
  int unsigned      wcnt = 0;
  bit               s_rd = 0, s_hs = 0;

  // Burst scoreboard
  int exp_addr = 0, beats_left = 0, want_len = -1, last_len = -1;
  int nbursts = 0, nbeats = 0, cyc = 0, t_first = -1, t_req = -1;
  bit req_pend = 0;
  logic [7:0]       held_len;
  logic [ADDRS-1:0] held_addr;
  int n0, b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    s_rd = ready_o;
    s_hs = ready_o && valid_i;
    if (!busy_o) check("idle_quiet", {ready_o, valid_o}, 0);
    if (t_first < 0 && (level_i != 0 || valid_i)) t_first = cyc;
    if (req_valid_o) begin
      if (t_req < 0) t_req = cyc;
      if (req_pend) begin
        check("req_len_stable", req_len_o, held_len);
        check("req_addr_stable", req_addr_o, held_addr);
      end else begin
        check("req_addr", req_addr_o, exp_addr);
        if (want_len >= 0) check("req_len", req_len_o, want_len);
      end
      held_len  = req_len_o;
      held_addr = req_addr_o;
      if (req_ready_i) begin
        req_pend   = 0;
        beats_left = int'(req_len_o) + 1;
        last_len   = int'(req_len_o);
        exp_addr   = (exp_addr + beats_left * (WIDTH / 8)) % (1 << ADDRS);
        nbursts++;
      end else begin
        req_pend = 1;
      end
    end
    if (valid_o) begin
      check("beat_in_burst", beats_left > 0, 1);
      check("last", last_o, beats_left == 1);
      if (ready_i) begin
        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
        else check("data", data_o, exp_q.pop_front());
        beats_left--;
        nbeats++;
      end
    end
  endtask

  task automatic update();
    logic [WIDTH-1:0] w;
    if (s_hs) out_valid = 0;
    if (s_rd && !out_valid && mem.size() > 0) begin
      out_reg   = mem.pop_front();
      out_valid = 1;
    end
    if (push_n > 0 && mem.size() < 16 && $urandom_range(99) < push_prob) begin
      w = seq_data ? WIDTH'(wcnt) : WIDTH'($urandom);
      wcnt++;
      mem.push_back(w);
      exp_q.push_back(w);
      push_n--;
    end
    level_i   = ABITS'(mem.size());
    fwready_i = (mem.size() < 16);
    valid_i   = out_valid;
    data_i    = out_valid ? out_reg : WIDTH'($urandom);
    ready_i     = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
    req_ready_i = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
  endtask

  task automatic cycle();
    @(negedge clock);
    if (!reset) monitor();
    else begin s_rd = 0; s_hs = 0; end
    @(posedge clock);
    #1;
    cyc++;
    update();
  endtask

  task automatic model_clear();
    mem.delete();
    exp_q.delete();
    out_valid = 0; push_n = 0; beats_left = 0; req_pend = 0; exp_addr = 0;
    level_i = '0; fwready_i = 1'b1; valid_i = 1'b0;
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    repeat (3) cycle();
    check("rst_req_valid", req_valid_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_len", req_len_o, 0);
    check("rst_addr", req_addr_o, 0);
    reset = 1'b0;
    model_clear();

    // Full burst of words 0..7
    enable_i = 1'b1; seq_data = 1; wcnt = 0; want_len = 7; push_n = 8;
    for (int i = 0; i < 100 && !(nbeats == 8 && !busy_o); i++) cycle();
    check("A_beats", nbeats, 8);
    check("A_bursts", nbursts, 1);

    // Backpressure: 40 random words, random ready/req_ready, then drain
    seq_data = 0; rand_rdy = 1; push_prob = 60; push_n = 40; n0 = nbeats; b0 = nbursts;
    for (int i = 0; i < 4000 && !(push_n == 0 && !busy_o && !req_valid_o && exp_q.size() < 9); i++) cycle();
    check("B_push_done", push_n, 0);
    rand_rdy = 0; want_len = -1; flush_i = 1'b1;
    for (int i = 0; i < 500 && !(exp_q.size() == 0 && !busy_o); i++) cycle();
    flush_i = 1'b0;
    check("B_words", nbeats - n0, 40);
    check("B_bursts", (nbursts - b0) >= 5, 1);

    // Flush of 3 words
    seq_data = 1; push_prob = 100; push_n = 3; n0 = nbeats;
    repeat (5) cycle();
    check("C1_no_early_req", busy_o, 0);
    want_len = 2; flush_i = 1'b1;
    for (int i = 0; i < 50 && !(nbeats - n0 == 3 && !busy_o); i++) cycle();
    flush_i = 1'b0;
    check("C1_beats", nbeats - n0, 3);
    check("C1_len", last_len, 2);

    // Full FIFO: leave one word in the output register, then fill memory
    want_len = 7; push_n = 9; n0 = nbeats;
    for (int i = 0; i < 100 && !(nbeats - n0 == 8 && !busy_o); i++) cycle();
    check("D_first_burst", nbeats - n0, 8);
    enable_i = 1'b0; push_n = 16;
    for (int i = 0; i < 60 && push_n != 0; i++) cycle();
    cycle(); cycle();
    check("D_held_idle", busy_o, 0);
    check("D_full_flag", fwready_i, 0);
    b0 = nbursts;
    enable_i = 1'b1;
    for (int i = 0; i < 3 && !req_valid_o; i++) cycle();
    check("D_full_req", req_valid_o, 1);
    for (int i = 0; i < 200 && !(nbursts == b0 + 2 && beats_left == 0 && !busy_o); i++) cycle();
    check("D_two_bursts", nbursts - b0, 2);
    check("D_residual", exp_q.size(), 1);

    // Residual only in the FIFO output register -> len 0
    want_len = 0; flush_i = 1'b1;
    for (int i = 0; i < 30 && !(exp_q.size() == 0 && !busy_o); i++) cycle();
    flush_i = 1'b0;
    check("C2_len", last_len, 0);
    check("C2_drained", exp_q.size(), 0);

    // Idle timeout
    want_len = 1; t_first = -1; t_req = -1; push_n = 2;
`ifdef BURST_READER_TIMEOUT_EN
    for (int i = 0; i < 200 && t_req < 0; i++) cycle();
    check("timeout_latency", t_req - t_first, 65);
`else
    repeat (150) cycle();
    check("no_timeout_req", t_req, -1);
    flush_i = 1'b1;
`endif
    for (int i = 0; i < 50 && !(exp_q.size() == 0 && !busy_o); i++) cycle();
    flush_i = 1'b0;
    check("T_drained", exp_q.size(), 0);

    // Reset in the middle of a burst
    want_len = 7; push_n = 8; n0 = nbeats;
    for (int i = 0; i < 100 && (nbeats - n0) < 3; i++) cycle();
    check("R_mid_burst", busy_o, 1);
    reset = 1'b1;
    cycle();
    check("R_busy", busy_o, 0);
    check("R_addr", req_addr_o, 0);
    check("R_valid", valid_o, 0);
    check("R_req_valid", req_valid_o, 0);
    reset = 1'b0;
    model_clear();
    push_n = 8; n0 = nbeats;
    for (int i = 0; i < 100 && !(nbeats - n0 == 8 && !busy_o); i++) cycle();
    check("R_after_beats", nbeats - n0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
